// File: rtl/pkt_store_fwd_fifo.sv
// rtl/pkt_store_fwd_fifo.sv - store-and-forward packet FIFO with whole-packet drop on overflow
module pkt_store_fwd_fifo #(
  parameter int DATA_W = 256,
  parameter int KEEP_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic              s_decomp,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              m_decomp,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int ENTRY_W = DATA_W + KEEP_W + 2;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_t;

  wstate_t            wstate, wstate_nxt;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_entry;
  logic [ADDR_W:0]    wr_ptr, wr_commit, rd_ptr, used;
  logic               full, accept, pkt_flag, beat_flag;
  logic               do_write, do_commit, do_rollback, do_drop_cnt;
  logic               have_data, rd_en;

  assign accept    = s_axis_tvalid & s_axis_tready;
  assign used      = wr_ptr - rd_ptr;
  // Full is judged on registered pointers only; a read this cycle frees space next cycle.
  assign full      = (used == (ADDR_W+1)'(DEPTH));
  assign have_data = (rd_ptr != wr_commit);
  assign rd_en     = have_data & (~m_axis_tvalid | m_axis_tready);
  assign rd_entry  = mem[rd_ptr[ADDR_W-1:0]];

  // Write FSM next state and per-beat actions.
  always_comb begin
    wstate_nxt  = wstate;
    do_write    = 1'b0;
    do_commit   = 1'b0;
    do_rollback = 1'b0;
    do_drop_cnt = 1'b0;
    beat_flag   = pkt_flag;
    case (wstate)
      W_IDLE: begin
        if (accept) begin
          beat_flag = s_decomp;
          if (full) begin
            do_drop_cnt = 1'b1;
            wstate_nxt  = s_axis_tlast ? W_IDLE : W_DROP;
          end else begin
            do_write = 1'b1;
            if (s_axis_tlast) do_commit = 1'b1;
            else              wstate_nxt = W_PKT;
          end
        end
      end
      W_PKT: begin
        if (accept) begin
          if (full) begin
            do_rollback = 1'b1;
            do_drop_cnt = 1'b1;
            wstate_nxt  = s_axis_tlast ? W_IDLE : W_DROP;
          end else begin
            do_write = 1'b1;
            if (s_axis_tlast) begin
              do_commit  = 1'b1;
              wstate_nxt = W_IDLE;
            end
          end
        end
      end
      W_DROP: begin
        if (accept && s_axis_tlast) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // Write-side state: FSM, pointers, packet flag, statistics.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wstate        <= W_IDLE;
      s_axis_tready <= 1'b0;
      pkt_flag      <= 1'b0;
      wr_ptr        <= '0;
      wr_commit     <= '0;
      pkt_cnt       <= '0;
      drop_cnt      <= '0;
    end else begin
      wstate        <= wstate_nxt;
      s_axis_tready <= 1'b1;
      if (wstate == W_IDLE && accept) pkt_flag <= s_decomp;
      if (do_write)         wr_ptr <= wr_ptr + PTR_ONE;
      else if (do_rollback) wr_ptr <= wr_commit;
      if (do_commit) begin
        wr_commit <= wr_ptr + PTR_ONE;
        if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + CNT_ONE;
      end
      if (do_drop_cnt && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

  // Packet storage; entries beyond wr_commit are invisible to the reader.
  always_ff @(posedge aclk) begin
    if (do_write)
      mem[wr_ptr[ADDR_W-1:0]] <= {beat_flag, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // Output register: refill from committed storage whenever it is empty or being consumed.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_decomp      <= 1'b0;
    end else if (rd_en) begin
      rd_ptr        <= rd_ptr + PTR_ONE;
      m_axis_tvalid <= 1'b1;
      {m_decomp, m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= rd_entry;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pkt_store_fwd_fifo.sv
// tb/tb_pkt_store_fwd_fifo.sv - scoreboard bench for pkt_store_fwd_fifo
module tb_pkt_store_fwd_fifo;

  localparam int DATA_W = 256;
  localparam int KEEP_W = 32;
  localparam int ENT_W  = DATA_W + KEEP_W + 2;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic [KEEP_W-1:0] s_axis_tkeep = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic              s_decomp = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b1;
  logic              m_decomp;
  logic [15:0]       pkt_cnt;
  logic [15:0]       drop_cnt;

  logic [ENT_W-1:0]  sb [$];
  int total = 0;
  int bad = 0;

  pkt_store_fwd_fifo dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .s_decomp(s_decomp),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .m_decomp(m_decomp),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  // Monitor: every accepted output beat is popped from the scoreboard and compared.
  always @(negedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got data=%h last=%b", m_axis_tdata, m_axis_tlast);
      end else begin
        logic [ENT_W-1:0] e;
        e = sb.pop_front();
        if ({m_decomp, m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== e) begin
          bad++;
          $display("FAIL beat: got dec=%b last=%b keep=%h data=%h want dec=%b last=%b keep=%h data=%h",
                   m_decomp, m_axis_tlast, m_axis_tkeep, m_axis_tdata,
                   e[ENT_W-1], e[ENT_W-2], e[DATA_W+KEEP_W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int pid, input int beat);
    logic [31:0] w;
    w = {pid[15:0], beat[15:0]};
    return {8{w}};
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    sb.delete();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_pkt(input int pid, input int n, input logic dec,
                          input logic [KEEP_W-1:0] lkeep, input bit expect_out);
    for (int b = 0; b < n; b++) begin
      logic last;
      logic [KEEP_W-1:0] k;
      last = (b == n - 1);
      k = last ? lkeep : {KEEP_W{1'b1}};
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = mk_data(pid, b);
      s_axis_tkeep  = k;
      s_axis_tlast  = last;
      s_decomp      = (b == 0) ? dec : ~dec;
      if (expect_out) sb.push_back({dec, last, k, mk_data(pid, b)});
      @(posedge aclk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    m_axis_tready = 1'b1;
    while (sb.size() != 0 && k < 500) begin
      @(posedge aclk);
      k++;
    end
    repeat (4) @(posedge aclk);
    #1;
    check({name, "_drained"}, sb.size(), 0);
    check({name, "_idle_tvalid"}, int'(m_axis_tvalid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    check("rst_s_tready", int'(s_axis_tready), 0);
    check("rst_m_tvalid", int'(m_axis_tvalid), 0);
    check("rst_pkt_cnt", int'(pkt_cnt), 0);
    check("rst_drop_cnt", int'(drop_cnt), 0);
    do_reset();
    check("s_tready_up", int'(s_axis_tready), 1);

    // 1: short packet, latency of first beat after tlast
    m_axis_tready = 1'b1;
    send_pkt(1, 3, 1'b1, 32'h000003ff, 1'b1);
    check("t1_tvalid_n1", int'(m_axis_tvalid), 0);
    @(posedge aclk);
    #1;
    check("t1_tvalid_n2", int'(m_axis_tvalid), 1);
    check("t1_decomp", int'(m_decomp), 1);
    drain("t1");
    check("t1_pkt_cnt", int'(pkt_cnt), 1);

    // 2: 45-beat packet held back, then released
    m_axis_tready = 1'b0;
    send_pkt(2, 45, 1'b0, 32'hffffffff, 1'b1);
    repeat (3) @(posedge aclk);
    #1;
    check("t2_held_tvalid", int'(m_axis_tvalid), 1);
    check("t2_held_tlast", int'(m_axis_tlast), 0);
    drain("t2");
    check("t2_pkt_cnt", int'(pkt_cnt), 2);
    check("t2_drop_cnt", int'(drop_cnt), 0);

    // 3: full FIFO drops the following packet whole
    do_reset();
    m_axis_tready = 1'b0;
    send_pkt(3, 64, 1'b1, 32'h0000ffff, 1'b1);
    send_pkt(4, 2, 1'b0, 32'hffffffff, 1'b0);
    @(posedge aclk);
    #1;
    check("t3_drop_cnt", int'(drop_cnt), 1);
    check("t3_pkt_cnt", int'(pkt_cnt), 1);
    drain("t3");

    // 4: oversize packet is dropped, next one passes
    m_axis_tready = 1'b1;
    send_pkt(5, 70, 1'b1, 32'hffffffff, 1'b0);
    send_pkt(6, 1, 1'b1, 32'h0000000f, 1'b1);
    drain("t4");
    check("t4_drop_cnt", int'(drop_cnt), 2);
    check("t4_pkt_cnt", int'(pkt_cnt), 2);

    // 5: toggling back-pressure over three back-to-back packets
    m_axis_tready = 1'b1;
    fork
      begin
        send_pkt(7, 10, 1'b0, 32'h00ff00ff, 1'b1);
        send_pkt(8, 10, 1'b1, 32'h0000000f, 1'b1);
        send_pkt(9, 10, 1'b0, 32'h80000001, 1'b1);
      end
      begin
        repeat (80) begin
          @(posedge aclk);
          #1 m_axis_tready = ~m_axis_tready;
        end
      end
    join
    drain("t5");
    check("t5_pkt_cnt", int'(pkt_cnt), 5);

    // 6: reset in the middle of a packet with a committed packet pending
    m_axis_tready = 1'b0;
    send_pkt(10, 3, 1'b1, 32'hffffffff, 1'b0);
    send_pkt(11, 4, 1'b0, 32'hffffffff, 1'b0);
    check("t6_pre_tvalid", int'(m_axis_tvalid), 1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mk_data(11, 4);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    s_axis_tvalid = 1'b0;
    sb.delete();
    check("t6_tvalid", int'(m_axis_tvalid), 0);
    check("t6_pkt_cnt", int'(pkt_cnt), 0);
    check("t6_drop_cnt", int'(drop_cnt), 0);
    check("t6_s_tready", int'(s_axis_tready), 0);
    @(posedge aclk);
    #1;
    check("t6_s_tready_up", int'(s_axis_tready), 1);
    m_axis_tready = 1'b1;
    send_pkt(12, 10, 1'b1, 32'h00000001, 1'b1);
    drain("t6");
    check("t6_pkt_cnt_after", int'(pkt_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
